// File: rtl/seg_pkg.sv
// seg_pkg: shared constants and helpers for the seven-segment scan multiplexer.
//   - segment bit positions inside the 8-bit seg_data word
//   - active-high glyph table for hex digits 0-F (b and d lowercase)
//   - per-digit storage record (nibble, decimal point, blank)
//   - polarity helpers applied only at the output registers
package seg_pkg;

  // Bit positions within seg_data (active-high view).
  localparam int SEG_A  = 0;
  localparam int SEG_B  = 1;
  localparam int SEG_C  = 2;
  localparam int SEG_D  = 3;
  localparam int SEG_E  = 4;
  localparam int SEG_F  = 5;
  localparam int SEG_G  = 6;
  localparam int SEG_DP = 7;

  // Glyphs as {g,f,e,d,c,b,a}, 1 = segment lit.
  localparam logic [6:0] GLYPH_0 = 7'h3F;
  localparam logic [6:0] GLYPH_1 = 7'h06;
  localparam logic [6:0] GLYPH_2 = 7'h5B;
  localparam logic [6:0] GLYPH_3 = 7'h4F;
  localparam logic [6:0] GLYPH_4 = 7'h66;
  localparam logic [6:0] GLYPH_5 = 7'h6D;
  localparam logic [6:0] GLYPH_6 = 7'h7D;
  localparam logic [6:0] GLYPH_7 = 7'h07;
  localparam logic [6:0] GLYPH_8 = 7'h7F;
  localparam logic [6:0] GLYPH_9 = 7'h6F;
  localparam logic [6:0] GLYPH_A = 7'h77;
  localparam logic [6:0] GLYPH_B = 7'h7C;  // lowercase b
  localparam logic [6:0] GLYPH_C = 7'h39;
  localparam logic [6:0] GLYPH_D = 7'h5E;  // lowercase d
  localparam logic [6:0] GLYPH_E = 7'h79;
  localparam logic [6:0] GLYPH_F = 7'h71;

  // One digit of shadow or display storage.
  typedef struct packed {
    logic [3:0] data;
    logic       dp;
    logic       blank;
  } digit_t;

  // Reset value of every stored digit: dark, nibble 0, no decimal point.
  localparam digit_t DIGIT_RESET = '{data: 4'h0, dp: 1'b0, blank: 1'b1};

  // Convert an active-high segment word to the pin polarity.
  function automatic logic [7:0] seg_polarity(input logic [7:0] v, input int active_low);
    return (active_low != 0) ? ~v : v;
  endfunction

  // Convert an active-high common-enable word (up to 16 digits) to pin polarity.
  function automatic logic [15:0] com_polarity(input logic [15:0] v, input int active_low);
    return (active_low != 0) ? ~v : v;
  endfunction

endpackage

// File: rtl/seg_hex_decode.sv
// seg_hex_decode: combinational hex nibble to seven-segment decoder.
// Ports:
//   nibble - 4-bit hex value
//   seg    - 7 segments {g,f,e,d,c,b,a}, active-high
module seg_hex_decode
  import seg_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  always_comb begin
    seg = GLYPH_0;
    case (nibble)
      4'h0: seg = GLYPH_0;
      4'h1: seg = GLYPH_1;
      4'h2: seg = GLYPH_2;
      4'h3: seg = GLYPH_3;
      4'h4: seg = GLYPH_4;
      4'h5: seg = GLYPH_5;
      4'h6: seg = GLYPH_6;
      4'h7: seg = GLYPH_7;
      4'h8: seg = GLYPH_8;
      4'h9: seg = GLYPH_9;
      4'hA: seg = GLYPH_A;
      4'hB: seg = GLYPH_B;
      4'hC: seg = GLYPH_C;
      4'hD: seg = GLYPH_D;
      4'hE: seg = GLYPH_E;
      4'hF: seg = GLYPH_F;
      default: seg = GLYPH_0;
    endcase
  end

endmodule

// File: rtl/seg_scan_mux.sv
// seg_scan_mux: time-multiplexed seven-segment display driver with a
// double-buffered digit store.
//
// A prescaler divides mclk into digit slots of SCAN_DIV cycles. Each slot
// lights one digit; the first BLANK_CYC cycles of a slot keep every common
// line off so the previous digit's segments do not ghost onto the next one.
//
// Host writes land in a shadow buffer. A commit request is held pending and
// the whole shadow is copied to the display buffer only at the end of a
// frame (tick while the last digit is shown), so a frame never mixes old
// and new contents.
//
// Ports:
//   mclk     - clock, all state on the rising edge
//   rst      - asynchronous active-high reset
//   wr_en    - write one shadow digit this cycle
//   wr_addr  - shadow digit index (indices >= N_DIGITS are ignored)
//   wr_data  - hex nibble for that digit
//   wr_dp    - decimal point on for that digit
//   wr_blank - digit fully dark when set
//   commit   - request shadow-to-display copy at the next frame boundary
//   busy     - high while a commit is pending
//   seg_com  - one-hot digit enable (polarity COM_ACTIVE_LOW)
//   seg_data - {dp, g..a} segments (polarity SEG_ACTIVE_LOW)
//
// Handshake: there is no ready on the write port; every wr_en cycle is
// accepted. commit is a one-cycle request; busy reports that a copy is
// still outstanding, and further commits while busy merge into it.
module seg_scan_mux
  import seg_pkg::*;
#(
  parameter int N_DIGITS       = 8,
  parameter int SCAN_DIV       = 1000,
  parameter int BLANK_CYC      = 2,
  parameter int COM_ACTIVE_LOW = 1,
  parameter int SEG_ACTIVE_LOW = 1
) (
  input  logic                        mclk,
  input  logic                        rst,
  input  logic                        wr_en,
  input  logic [$clog2(N_DIGITS)-1:0] wr_addr,
  input  logic [3:0]                  wr_data,
  input  logic                        wr_dp,
  input  logic                        wr_blank,
  input  logic                        commit,
  output logic                        busy,
  output logic [N_DIGITS-1:0]         seg_com,
  output logic [7:0]                  seg_data
);

  localparam int AW = $clog2(N_DIGITS);
  localparam int PW = $clog2(SCAN_DIV);

  localparam logic [PW-1:0] PRESC_LAST = PW'(SCAN_DIV - 1);
  localparam logic [AW-1:0] IDX_LAST   = AW'(N_DIGITS - 1);

  // Output values while in reset: every common line and segment off.
  localparam logic [15:0] COM_OFF_W = com_polarity(16'h0000, COM_ACTIVE_LOW);
  localparam logic [N_DIGITS-1:0] COM_OFF = COM_OFF_W[N_DIGITS-1:0];
  localparam logic [7:0] SEG_OFF = seg_polarity(8'h00, SEG_ACTIVE_LOW);

  // Scan state.
  logic [PW-1:0] presc_q, presc_d;
  logic [AW-1:0] idx_q, idx_d;
  logic          tick;

  // Commit state.
  logic pending_q, pending_d;
  logic swap;

  // Digit buffers, kept as flat registers.
  digit_t shadow_q  [N_DIGITS];
  digit_t shadow_d  [N_DIGITS];
  digit_t display_q [N_DIGITS];
  digit_t display_d [N_DIGITS];

  // Output path, active-high until the final polarity stage.
  digit_t                cur_digit;
  logic [6:0]            glyph;
  logic [N_DIGITS-1:0]   com_hi;
  logic [7:0]            seg_hi;
  logic [15:0]           com_pin_w;
  logic [N_DIGITS-1:0]   seg_com_d;
  logic [7:0]            seg_data_d;

  logic [N_DIGITS-1:0]   seg_com_q;
  logic [7:0]            seg_data_q;

  // ---------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------
  always_comb begin
    tick    = (presc_q == PRESC_LAST);
    presc_d = tick ? '0 : presc_q + PW'(1);

    idx_d = idx_q;
    if (tick) begin
      idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + AW'(1);
    end
  end

  // Shadow write. The updated shadow (including this cycle's write) is what
  // a swap on this same edge copies into the display.
  always_comb begin
    for (int i = 0; i < N_DIGITS; i++) begin
      shadow_d[i] = shadow_q[i];
    end
    if (wr_en && (int'(wr_addr) < N_DIGITS)) begin
      shadow_d[wr_addr] = '{data: wr_data, dp: wr_dp, blank: wr_blank};
    end
  end

  // Frame-boundary swap. A commit arriving in the swap cycle itself is
  // served by that swap instead of leaving a fresh pending request behind.
  always_comb begin
    swap      = tick && (idx_q == IDX_LAST) && (pending_q || commit);
    pending_d = swap ? 1'b0 : (pending_q || commit);
    for (int i = 0; i < N_DIGITS; i++) begin
      display_d[i] = swap ? shadow_d[i] : display_q[i];
    end
  end

  // ---------------------------------------------------------------------
  // Output formation
  // The output registers are loaded from next-state scan values so that
  // seg_com/seg_data line up with the prescaler slot they belong to: the
  // cycle after a tick already shows the new digit (and its blank window).
  // ---------------------------------------------------------------------
  assign cur_digit = display_d[idx_d];

  seg_hex_decode u_hex_decode (
    .nibble (cur_digit.data),
    .seg    (glyph)
  );

  always_comb begin
    com_hi = '0;
    if (int'(presc_d) >= BLANK_CYC) begin
      com_hi[idx_d] = 1'b1;
    end

    seg_hi = '0;
    if (!cur_digit.blank) begin
      seg_hi[SEG_DP]      = cur_digit.dp;
      seg_hi[SEG_G:SEG_A] = glyph;
    end

    com_pin_w  = com_polarity(16'(com_hi), COM_ACTIVE_LOW);
    seg_com_d  = com_pin_w[N_DIGITS-1:0];
    seg_data_d = seg_polarity(seg_hi, SEG_ACTIVE_LOW);
  end

  // ---------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------
  always_ff @(posedge mclk or posedge rst) begin
    if (rst) begin
      presc_q   <= '0;
      idx_q     <= '0;
      pending_q <= 1'b0;
      for (int i = 0; i < N_DIGITS; i++) begin
        shadow_q[i]  <= DIGIT_RESET;
        display_q[i] <= DIGIT_RESET;
      end
      seg_com_q  <= COM_OFF;
      seg_data_q <= SEG_OFF;
    end else begin
      presc_q   <= presc_d;
      idx_q     <= idx_d;
      pending_q <= pending_d;
      for (int i = 0; i < N_DIGITS; i++) begin
        shadow_q[i]  <= shadow_d[i];
        display_q[i] <= display_d[i];
      end
      seg_com_q  <= seg_com_d;
      seg_data_q <= seg_data_d;
    end
  end

  assign busy     = pending_q;
  assign seg_com  = seg_com_q;
  assign seg_data = seg_data_q;

endmodule

// File: tb/tb_seg_scan_mux.sv
module tb_seg_scan_mux;

  // Bench configuration: 4 digits, 4-cycle slots, 1 blank cycle, active-low.
  localparam int N  = 4;
  localparam int SD = 4;

  logic       mclk;
  logic       rst;
  logic       wr_en;
  logic [1:0] wr_addr;
  logic [3:0] wr_data;
  logic       wr_dp;
  logic       wr_blank;
  logic       commit;
  logic       busy;
  logic [3:0] seg_com;
  logic [7:0] seg_data;

  int checks = 0;
  int errors = 0;
  int k      = 0;  // rising edges since reset release

  logic [3:0] exp_q[$];

  seg_scan_mux #(
    .N_DIGITS       (N),
    .SCAN_DIV       (SD),
    .BLANK_CYC      (1),
    .COM_ACTIVE_LOW (1),
    .SEG_ACTIVE_LOW (1)
  ) dut (
    .mclk     (mclk),
    .rst      (rst),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .wr_dp    (wr_dp),
    .wr_blank (wr_blank),
    .commit   (commit),
    .busy     (busy),
    .seg_com  (seg_com),
    .seg_data (seg_data)
  );

  // Clock / reset
  initial mclk = 1'b0;
  always #5 mclk = ~mclk;

  // Expected active-low common word after k edges since reset release.
  function automatic logic [3:0] model_com(input int kk);
    int presc;
    int idx;
    logic [3:0] one;
    presc = kk % SD;
    idx   = (kk / SD) % N;
    one   = 4'b0001 << idx;
    return (presc == 0) ? 4'hF : ~one;
  endfunction

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s k=%0d observed=%h expected=%h", tag, k, obs, exp);
    end
  endtask

  // Driver tasks; called at a falling edge, return at the next falling edge.
  task automatic step();
    @(posedge mclk);
    k++;
    @(negedge mclk);
  endtask

  task automatic run_to(input int target);
    while (k < target) step();
  endtask

  task automatic write_digit(input logic [1:0] a, input logic [3:0] d,
                             input logic dp, input logic bl, input logic cm);
    wr_en    = 1'b1;
    wr_addr  = a;
    wr_data  = d;
    wr_dp    = dp;
    wr_blank = bl;
    commit   = cm;
    step();
    wr_en  = 1'b0;
    commit = 1'b0;
  endtask

  task automatic do_commit();
    commit = 1'b1;
    step();
    commit = 1'b0;
  endtask

  initial begin
    rst = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    wr_dp = 1'b0; wr_blank = 1'b0; commit = 1'b0;

    // Reset state
    repeat (2) @(negedge mclk);
    chk("rst_com", 8'(seg_com), 8'h0F);
    chk("rst_data", seg_data, 8'hFF);
    chk("rst_busy", 8'(busy), 8'h00);
    rst = 1'b0;
    k = 0;

    // Scan sequence over 20 edges, display still blank
    for (int i = 1; i <= 20; i++) exp_q.push_back(model_com(i));
    for (int i = 1; i <= 20; i++) begin
      step();
      chk("scan_com", 8'(seg_com), 8'(exp_q.pop_front()));
      chk("scan_data", seg_data, 8'hFF);
    end

    // Commit: digits 1,2,3,F then commit; swap at edge 32
    write_digit(2'd0, 4'h1, 1'b0, 1'b0, 1'b0);
    write_digit(2'd1, 4'h2, 1'b0, 1'b0, 1'b0);
    write_digit(2'd2, 4'h3, 1'b0, 1'b0, 1'b0);
    write_digit(2'd3, 4'hF, 1'b0, 1'b0, 1'b0);
    chk("pre_commit_data", seg_data, 8'hFF);
    do_commit();
    chk("busy_after_commit", 8'(busy), 8'h01);
    run_to(31);
    chk("busy_before_swap", 8'(busy), 8'h01);
    chk("no_early_swap", seg_data, 8'hFF);
    step();
    chk("busy_after_swap", 8'(busy), 8'h00);
    chk("swap_d0_blankslot_com", 8'(seg_com), 8'h0F);
    chk("swap_d0_data", seg_data, 8'hF9);
    run_to(33); chk("d0_com", 8'(seg_com), 8'h0E); chk("d0_data", seg_data, 8'hF9);
    run_to(37); chk("d1_com", 8'(seg_com), 8'h0D); chk("d1_data", seg_data, 8'hA4);
    run_to(41); chk("d2_com", 8'(seg_com), 8'h0B); chk("d2_data", seg_data, 8'hB0);
    run_to(45); chk("d3_com", 8'(seg_com), 8'h07); chk("d3_data", seg_data, 8'h8E);

    // Write without commit: display unchanged for 3 frames
    run_to(48);
    write_digit(2'd0, 4'h8, 1'b0, 1'b0, 1'b0);
    for (int f = 1; f <= 3; f++) begin
      run_to(49 + 16 * f);
      chk("nocommit_com", 8'(seg_com), 8'h0E);
      chk("nocommit_data", seg_data, 8'hF9);
      chk("nocommit_busy", 8'(busy), 8'h00);
    end

    // Boundary: pending commit, then write+commit in the swap cycle (111->112)
    run_to(100);
    do_commit();
    chk("busy_pending", 8'(busy), 8'h01);
    run_to(111);
    write_digit(2'd0, 4'h5, 1'b0, 1'b0, 1'b1);
    chk("bnd_busy", 8'(busy), 8'h00);
    chk("bnd_data", seg_data, 8'h92);
    step();
    chk("bnd_com", 8'(seg_com), 8'h0E);
    chk("bnd_data2", seg_data, 8'h92);
    chk("bnd_busy2", 8'(busy), 8'h00);

    // Blank / dp: digit2 blank, digit3 dp with nibble 0; swap at 128
    run_to(114);
    write_digit(2'd2, 4'h7, 1'b0, 1'b1, 1'b0);
    write_digit(2'd3, 4'h0, 1'b1, 1'b0, 1'b0);
    do_commit();
    run_to(129); chk("bd_d0_data", seg_data, 8'h92);
    run_to(137); chk("bd_d2_com", 8'(seg_com), 8'h0B); chk("bd_d2_data", seg_data, 8'hFF);
    run_to(141); chk("bd_d3_com", 8'(seg_com), 8'h07); chk("bd_d3_data", seg_data, 8'h40);

    // Mid-scan reset abandons a pending commit
    run_to(144);
    do_commit();
    chk("pre_rst_busy", 8'(busy), 8'h01);
    chk("pre_rst_com", 8'(seg_com), 8'h0E);
    #2 rst = 1'b1;
    #1;
    chk("midrst_com", 8'(seg_com), 8'h0F);
    chk("midrst_data", seg_data, 8'hFF);
    chk("midrst_busy", 8'(busy), 8'h00);
    @(negedge mclk);
    rst = 1'b0;
    k = 0;
    step(); chk("post_rst_com", 8'(seg_com), 8'h0E); chk("post_rst_data", seg_data, 8'hFF);
    run_to(4); chk("post_rst_blank", 8'(seg_com), 8'h0F);
    run_to(5); chk("post_rst_d1", 8'(seg_com), 8'h0D);
    run_to(16); chk("post_rst_busy", 8'(busy), 8'h00); chk("post_rst_frame", seg_data, 8'hFF);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/seg_scan_mux.md
SEG_SCAN_MUX -- requirements
Module: seg_scan_mux

Interface
REQ-001 SHALL have parameter N_DIGITS, default 8, number of multiplexed digits (2..16).
REQ-002 SHALL have parameter SCAN_DIV, default 1000, mclk cycles per digit slot (>= 4).
REQ-003 SHALL have parameter BLANK_CYC, default 2, anti-ghost cycles at start of each slot (< SCAN_DIV).
REQ-004 SHALL have parameter COM_ACTIVE_LOW, default 1, selects seg_com polarity.
REQ-005 SHALL have parameter SEG_ACTIVE_LOW, default 1, selects seg_data polarity.
REQ-006 SHALL have port mclk, input, 1, the single clock; all state on its rising edge.
REQ-007 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-008 SHALL have port wr_en, input, 1, write one shadow digit this cycle.
REQ-009 SHALL have port wr_addr, input, clog2(N_DIGITS), shadow digit index.
REQ-010 SHALL have port wr_data, input, 4, hex nibble for that digit.
REQ-011 SHALL have port wr_dp, input, 1, decimal point on for that digit.
REQ-012 SHALL have port wr_blank, input, 1, digit fully dark when set.
REQ-013 SHALL have port commit, input, 1, request shadow-to-display copy.
REQ-014 SHALL have port busy, output, 1, high while a commit is pending.
REQ-015 SHALL have port seg_com, output, N_DIGITS, one-hot digit enable.
REQ-016 SHALL have port seg_data, output, 8, bit7 = dp, bits6..0 = segments g..a.

Function
REQ-017 SHALL run a prescaler 0..SCAN_DIV-1; tick = prescaler at SCAN_DIV-1; prescaler wraps to 0.
REQ-018 SHALL advance digit index idx on tick, 0..N_DIGITS-1, wrapping N_DIGITS-1 -> 0.
REQ-019 SHALL register seg_com and seg_data; both reflect new idx on cycle after tick (latency 1).
REQ-020 SHALL hold all seg_com bits inactive while prescaler < BLANK_CYC (slot start), else assert only bit idx.
REQ-021 SHALL drive seg_data from display entry idx via hex decode (0-9, A-F standard glyphs, b/d lowercase), dp from stored dp.
REQ-022 SHALL drive seg_data all-off (including dp) when the entry's blank bit is set; seg_com still scans.
REQ-023 SHALL write {wr_data, wr_dp, wr_blank} into shadow[wr_addr] when wr_en; wr_addr >= N_DIGITS ignored.
REQ-024 SHALL set pending on commit; busy = pending; extra commits while pending merge.
REQ-025 SHALL copy whole shadow to display on frame boundary (tick with idx = N_DIGITS-1) when pending, clearing pending same edge.
REQ-026 SHALL include a same-cycle wr_en write in the copy; a same-cycle commit with swap sets no new pending.
REQ-027 SHALL leave display untouched by writes without commit (no tearing mid-frame).
REQ-028 SHALL apply polarity parameters only at the output register; internal logic active-high.

Reset
REQ-029 SHALL on rst asynchronously clear prescaler, idx = 0, pending = 0, busy = 0.
REQ-030 SHALL on rst set all shadow and display entries to blank = 1, data = 0, dp = 0.
REQ-031 SHALL on rst drive seg_com all inactive and seg_data all off; rst mid-frame abandons pending commit.
REQ-032 SHALL resume scanning from idx 0, prescaler 0, first cycle after rst deasserts.

Structure
REQ-033 SHALL place glyph table constants, segment bit positions and polarity helpers in package seg_pkg.
REQ-034 SHALL instantiate one sub-module seg_hex_decode (4-bit nibble -> 7 active-high segments, combinational).
REQ-035 SHALL keep the digit buffers as flat registers, no RAM inference.

Verification (bench: N_DIGITS=4, SCAN_DIV=4, BLANK_CYC=1, active-low)
REQ-036 SHALL check reset: rst pulse mid-scan -> seg_com=4'b1111, seg_data=8'hFF immediately, busy=0.
REQ-037 SHALL check scan: after reset, seg_com low bit cycles 0,1,2,3,0 every 4 clocks, all-high 1 clock each slot start.
REQ-038 SHALL check commit: write digits 1,2,3,F, commit -> busy high until frame boundary, then digit0 seg_data=8'hF9 (glyph "1").
REQ-039 SHALL check no-commit write: write digit0=8 without commit -> display unchanged over 3 frames.
REQ-040 SHALL check boundary: write+commit in the swap cycle -> written value shown next frame, busy low after swap.
REQ-041 SHALL check blank/dp: digit2 blank=1, digit3 dp=1 data=0 -> slot2 8'hFF, slot3 8'h40.
